// File: rtl/ripemd160_pkg.sv
// Shared definitions for the single-block RIPEMD-160 engine.
// Holds the IV, round constants, word-select and rotate tables, the
// boolean round functions and small bit helpers, plus the FSM encoding.
package ripemd160_pkg;

    typedef enum logic [1:0] {StIdle, StRound, StFinal} state_t;

    // One line of working registers; A is the most significant word.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
    } line_t;

    localparam logic [31:0] Iv0 = 32'h67452301;
    localparam logic [31:0] Iv1 = 32'hEFCDAB89;
    localparam logic [31:0] Iv2 = 32'h98BADCFE;
    localparam logic [31:0] Iv3 = 32'h10325476;
    localparam logic [31:0] Iv4 = 32'hC3D2E1F0;

    localparam line_t IvLine = '{a: Iv0, b: Iv1, c: Iv2, d: Iv3, e: Iv4};

    localparam int unsigned RlTab [80] = '{
        0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
        7, 4, 13, 1, 10, 6, 15, 3, 12, 0, 9, 5, 2, 14, 11, 8,
        3, 10, 14, 4, 9, 15, 8, 1, 2, 7, 0, 6, 13, 11, 5, 12,
        1, 9, 11, 10, 0, 8, 12, 4, 13, 3, 7, 15, 14, 5, 6, 2,
        4, 0, 5, 9, 7, 12, 2, 10, 14, 1, 3, 8, 11, 6, 15, 13};

    localparam int unsigned RrTab [80] = '{
        5, 14, 7, 0, 9, 2, 11, 4, 13, 6, 15, 8, 1, 10, 3, 12,
        6, 11, 3, 7, 0, 13, 5, 10, 14, 15, 8, 12, 4, 9, 1, 2,
        15, 5, 1, 3, 7, 14, 6, 9, 11, 8, 12, 2, 10, 0, 4, 13,
        8, 6, 4, 1, 3, 11, 15, 0, 5, 12, 2, 13, 9, 7, 10, 14,
        12, 15, 10, 4, 1, 5, 8, 7, 6, 2, 13, 14, 0, 3, 9, 11};

    localparam int unsigned SlTab [80] = '{
        11, 14, 15, 12, 5, 8, 7, 9, 11, 13, 14, 15, 6, 7, 9, 8,
        7, 6, 8, 13, 11, 9, 7, 15, 7, 12, 15, 9, 11, 7, 13, 12,
        11, 13, 6, 7, 14, 9, 13, 15, 14, 8, 13, 6, 5, 12, 7, 5,
        11, 12, 14, 15, 14, 15, 9, 8, 9, 14, 5, 6, 8, 6, 5, 12,
        9, 15, 5, 11, 6, 8, 13, 12, 5, 12, 13, 14, 11, 8, 5, 6};

    localparam int unsigned SrTab [80] = '{
        8, 9, 9, 11, 13, 15, 15, 5, 7, 7, 8, 11, 14, 14, 12, 6,
        9, 13, 15, 7, 12, 8, 9, 11, 7, 7, 12, 7, 6, 15, 13, 11,
        9, 7, 15, 11, 8, 6, 6, 14, 12, 13, 5, 14, 13, 13, 7, 5,
        15, 5, 8, 11, 14, 14, 6, 14, 6, 9, 12, 9, 12, 5, 15, 8,
        8, 5, 12, 9, 12, 5, 14, 6, 8, 13, 6, 5, 15, 13, 11, 11};

    function automatic logic [3:0] r_sel(logic [6:0] j, logic right);
        return right ? 4'(RrTab[j]) : 4'(RlTab[j]);
    endfunction

    function automatic logic [3:0] s_sel(logic [6:0] j, logic right);
        return right ? 4'(SrTab[j]) : 4'(SlTab[j]);
    endfunction

    // Group index is j/16, i.e. j[6:4] for j in 0..79.
    function automatic logic [31:0] k_sel(logic [2:0] grp, logic right);
        case (grp)
            3'd0:    return right ? 32'h50A28BE6 : 32'h00000000;
            3'd1:    return right ? 32'h5C4DD124 : 32'h5A827999;
            3'd2:    return right ? 32'h6D703EF3 : 32'h6ED9EBA1;
            3'd3:    return right ? 32'h7A6D76E9 : 32'h8F1BBCDC;
            default: return right ? 32'h00000000 : 32'hA953FD4E;
        endcase
    endfunction

    function automatic logic [31:0] rmd_f(logic [6:0] j, logic [31:0] x, logic [31:0] y,
                                          logic [31:0] z);
        case (j[6:4])
            3'd0:    return x ^ y ^ z;
            3'd1:    return (x & y) | (~x & z);
            3'd2:    return (x | ~y) ^ z;
            3'd3:    return (x & z) | (y & ~z);
            default: return x ^ (y | ~z);
        endcase
    endfunction

    function automatic logic [31:0] rol(logic [31:0] x, logic [4:0] s);
        return (x << s) | (x >> (6'd32 - {1'b0, s}));
    endfunction

    function automatic logic [31:0] bswap32(logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage

// File: rtl/ripemd160_step.sv
// Combinational RIPEMD-160 step for one line (left or right).
// Ports: round  - step index j (0..79)
//        right  - 1 selects the right-line function order and constants
//        cur    - current A..E
//        x      - message word already selected for this line and step
//        nxt    - A..E after the step
module ripemd160_step
    import ripemd160_pkg::*;
(
    input  logic [6:0]  round,
    input  logic        right,
    input  line_t       cur,
    input  logic [31:0] x,
    output line_t       nxt
);

    logic [6:0]  f_idx;
    logic [31:0] sum;

    always_comb begin
        // The right line walks the boolean functions in reverse order.
        f_idx = right ? (7'd79 - round) : round;
        sum   = cur.a + rmd_f(f_idx, cur.b, cur.c, cur.d) + x + k_sel(round[6:4], right);
        nxt.a = cur.e;
        nxt.b = rol(sum, {1'b0, s_sel(round, right)}) + cur.e;
        nxt.c = cur.b;
        nxt.d = rol(cur.c, 5'd10);
        nxt.e = cur.d;
    end

endmodule

// File: rtl/ripemd160_final.sv
// Iterative single-block RIPEMD-160 compression with IV load and final
// chaining addition. One step of both lines per clock: 1 load + 80 rounds
// + 1 final cycle.
// Ports: clk, rst_n  - clock, async active-low reset
//        i_valid     - start strobe, honoured only when idle
//        block       - 512-bit pre-padded block, word j = block[32j+:32]
//        o_valid     - one-cycle pulse when ans is updated
//        ans         - 160-bit digest, first byte in ans[159:152]
module ripemd160_final
    import ripemd160_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    input  logic [511:0] block,
    output logic         o_valid,
    output logic [159:0] ans
);

    state_t         state_q, state_d;
    logic [511:0]   blk_q, blk_d;
    logic [6:0]     round_q, round_d;
    line_t          left_q, left_d, right_q, right_d;
    line_t          left_nxt, right_nxt;
    logic           o_valid_q, o_valid_d;
    logic [159:0]   ans_q, ans_d;
    logic [31:0]    x_left, x_right;
    logic [31:0]    h0, h1, h2, h3, h4;

    assign x_left  = blk_q[{r_sel(round_q, 1'b0), 5'd0} +: 32];
    assign x_right = blk_q[{r_sel(round_q, 1'b1), 5'd0} +: 32];

    ripemd160_step u_step_left (
        .round (round_q),
        .right (1'b0),
        .cur   (left_q),
        .x     (x_left),
        .nxt   (left_nxt)
    );

    ripemd160_step u_step_right (
        .round (round_q),
        .right (1'b1),
        .cur   (right_q),
        .x     (x_right),
        .nxt   (right_nxt)
    );

    // Chaining addition; the IV words rotate by one position.
    assign h0 = Iv1 + left_q.c + right_q.d;
    assign h1 = Iv2 + left_q.d + right_q.e;
    assign h2 = Iv3 + left_q.e + right_q.a;
    assign h3 = Iv4 + left_q.a + right_q.b;
    assign h4 = Iv0 + left_q.b + right_q.c;

    always_comb begin
        state_d   = state_q;
        blk_d     = blk_q;
        round_d   = round_q;
        left_d    = left_q;
        right_d   = right_q;
        o_valid_d = 1'b0;
        ans_d     = ans_q;
        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    blk_d   = block;
                    left_d  = IvLine;
                    right_d = IvLine;
                    round_d = 7'd0;
                    state_d = StRound;
                end
            end
            StRound: begin
                left_d  = left_nxt;
                right_d = right_nxt;
                if (round_q == 7'd79) begin
                    // Park the counter at 0 so table lookups stay in range.
                    round_d = 7'd0;
                    state_d = StFinal;
                end else begin
                    round_d = round_q + 7'd1;
                end
            end
            StFinal: begin
                ans_d     = {bswap32(h0), bswap32(h1), bswap32(h2), bswap32(h3), bswap32(h4)};
                o_valid_d = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            blk_q     <= '0;
            round_q   <= '0;
            left_q    <= '0;
            right_q   <= '0;
            o_valid_q <= 1'b0;
            ans_q     <= '0;
        end else begin
            state_q   <= state_d;
            blk_q     <= blk_d;
            round_q   <= round_d;
            left_q    <= left_d;
            right_q   <= right_d;
            o_valid_q <= o_valid_d;
            ans_q     <= ans_d;
        end
    end

    assign o_valid = o_valid_q;
    assign ans     = ans_q;

endmodule

// File: tb/tb_ripemd160_final.sv
module tb_ripemd160_final;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic [511:0] block = '0;
    logic         o_valid;
    logic [159:0] ans;

    ripemd160_final dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .block   (block),
        .o_valid (o_valid),
        .ans     (ans)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int ov_count = 0;
    int ov_cyc = 0;
    logic [159:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    localparam int ZL [80] = '{
        0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
        7, 4, 13, 1, 10, 6, 15, 3, 12, 0, 9, 5, 2, 14, 11, 8,
        3, 10, 14, 4, 9, 15, 8, 1, 2, 7, 0, 6, 13, 11, 5, 12,
        1, 9, 11, 10, 0, 8, 12, 4, 13, 3, 7, 15, 14, 5, 6, 2,
        4, 0, 5, 9, 7, 12, 2, 10, 14, 1, 3, 8, 11, 6, 15, 13};
    localparam int ZR [80] = '{
        5, 14, 7, 0, 9, 2, 11, 4, 13, 6, 15, 8, 1, 10, 3, 12,
        6, 11, 3, 7, 0, 13, 5, 10, 14, 15, 8, 12, 4, 9, 1, 2,
        15, 5, 1, 3, 7, 14, 6, 9, 11, 8, 12, 2, 10, 0, 4, 13,
        8, 6, 4, 1, 3, 11, 15, 0, 5, 12, 2, 13, 9, 7, 10, 14,
        12, 15, 10, 4, 1, 5, 8, 7, 6, 2, 13, 14, 0, 3, 9, 11};
    localparam int SHL [80] = '{
        11, 14, 15, 12, 5, 8, 7, 9, 11, 13, 14, 15, 6, 7, 9, 8,
        7, 6, 8, 13, 11, 9, 7, 15, 7, 12, 15, 9, 11, 7, 13, 12,
        11, 13, 6, 7, 14, 9, 13, 15, 14, 8, 13, 6, 5, 12, 7, 5,
        11, 12, 14, 15, 14, 15, 9, 8, 9, 14, 5, 6, 8, 6, 5, 12,
        9, 15, 5, 11, 6, 8, 13, 12, 5, 12, 13, 14, 11, 8, 5, 6};
    localparam int SHR [80] = '{
        8, 9, 9, 11, 13, 15, 15, 5, 7, 7, 8, 11, 14, 14, 12, 6,
        9, 13, 15, 7, 12, 8, 9, 11, 7, 7, 12, 7, 6, 15, 13, 11,
        9, 7, 15, 11, 8, 6, 6, 14, 12, 13, 5, 14, 13, 13, 7, 5,
        15, 5, 8, 11, 14, 14, 6, 14, 6, 9, 12, 9, 12, 5, 15, 8,
        8, 5, 12, 9, 12, 5, 14, 6, 8, 13, 6, 5, 15, 13, 11, 11};
    localparam bit [31:0] KLT [5] = '{32'h0, 32'h5A827999, 32'h6ED9EBA1, 32'h8F1BBCDC,
                                      32'hA953FD4E};
    localparam bit [31:0] KRT [5] = '{32'h50A28BE6, 32'h5C4DD124, 32'h6D703EF3,
                                      32'h7A6D76E9, 32'h0};

    function automatic bit [31:0] m_rol(bit [31:0] v, int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic bit [31:0] m_f(int j, bit [31:0] x, bit [31:0] y, bit [31:0] z);
        if (j < 16) return x ^ y ^ z;
        else if (j < 32) return (x & y) | (~x & z);
        else if (j < 48) return (x | ~y) ^ z;
        else if (j < 64) return (x & z) | (y & ~z);
        else return x ^ (y | ~z);
    endfunction

    function automatic bit [31:0] m_sw(bit [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [159:0] model(logic [511:0] blk);
        bit [31:0] x [16];
        bit [31:0] h [5];
        bit [31:0] al, bl, cl, dl, el, ar, br, cr, dr, er, t, o0, o1, o2, o3, o4;
        h = '{32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0};
        for (int i = 0; i < 16; i++) x[i] = blk[i*32 +: 32];
        al = h[0]; bl = h[1]; cl = h[2]; dl = h[3]; el = h[4];
        ar = h[0]; br = h[1]; cr = h[2]; dr = h[3]; er = h[4];
        for (int j = 0; j < 80; j++) begin
            t = m_rol(al + m_f(j, bl, cl, dl) + x[ZL[j]] + KLT[j / 16], SHL[j]) + el;
            al = el; el = dl; dl = m_rol(cl, 10); cl = bl; bl = t;
            t = m_rol(ar + m_f(79 - j, br, cr, dr) + x[ZR[j]] + KRT[j / 16], SHR[j]) + er;
            ar = er; er = dr; dr = m_rol(cr, 10); cr = br; br = t;
        end
        o0 = h[1] + cl + dr;
        o1 = h[2] + dl + er;
        o2 = h[3] + el + ar;
        o3 = h[4] + al + br;
        o4 = h[0] + bl + cr;
        return {m_sw(o0), m_sw(o1), m_sw(o2), m_sw(o3), m_sw(o4)};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every o_valid pulse pops one expected digest.
    always @(negedge clk) begin
        if (rst_n && o_valid) begin
            ov_count++;
            ov_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL spurious_o_valid: got pulse at cycle %0d expected none", cyc);
            end else begin
                check("digest", ans, exp_q.pop_front());
            end
        end
    end

    task automatic start(input logic [511:0] blk, input logic [159:0] exp, output int smp);
        @(posedge clk);
        #1;
        block   = blk;
        i_valid = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        smp     = cyc;
        i_valid = 1'b0;
    endtask

    task automatic wait_done(input int base, output int lat);
        int seen;
        int n;
        seen = ov_count;
        n = 0;
        lat = -1;
        while (ov_count == seen && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (ov_count == seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout: got no o_valid after %0d cycles expected one", n);
        end else begin
            lat = ov_cyc - base;
        end
    endtask

    typedef struct {
        string        name;
        logic [511:0] blk;
        logic [159:0] exp;
    } vec_t;

    vec_t tab [3];
    logic [511:0] blk_empty, blk_abc, rblk;
    logic [159:0] dig_empty, dig_abc;

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int smp, lat, base_ov, first;
        blk_empty = '0;
        blk_empty[31:0] = 32'h00000080;
        blk_abc = '0;
        blk_abc[31:0] = 32'h80636261;
        blk_abc[14*32 +: 32] = 32'h00000018;
        dig_empty = 160'h9c1185a5c5e9fc54612808977ee8f548b2258d31;
        dig_abc   = 160'h8eb208f7e05d987a9b044a8e98c6b087f15a0bfc;
        tab[0] = '{name: "empty", blk: blk_empty, exp: dig_empty};
        tab[1] = '{name: "abc",   blk: blk_abc,   exp: dig_abc};
        tab[2] = '{name: "zeros", blk: '0,        exp: model('0)};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_ans", ans, 160'h0);
        check("reset_o_valid", {159'b0, o_valid}, 160'h0);
        rst_n = 1'b1;

        // Table vectors with latency check
        foreach (tab[i]) begin
            start(tab[i].blk, tab[i].exp, smp);
            wait_done(smp, lat);
            check({"latency_", tab[i].name}, lat, 81);
        end

        // Busy-ignore: i_valid with another block during rounds
        start(blk_abc, dig_abc, smp);
        base_ov = ov_count;
        repeat (9) @(posedge clk);
        #1;
        block   = blk_empty;
        i_valid = 1'b1;
        repeat (31) @(posedge clk);
        #1;
        i_valid = 1'b0;
        wait_done(smp, lat);
        check("busy_latency", lat, 81);
        repeat (200) @(negedge clk);
        check("busy_single_pulse", ov_count - base_ov, 1);

        // Back-to-back: start in the o_valid cycle
        start(blk_abc, dig_abc, smp);
        wait_done(smp, lat);
        first = ov_cyc;
        block   = blk_empty;
        i_valid = 1'b1;
        exp_q.push_back(dig_empty);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("b2b_ans_held", ans, dig_abc);
        wait_done(first, lat);
        check("b2b_spacing", lat, 82);

        // Reset mid-operation
        start(blk_abc, dig_abc, smp);
        repeat (39) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_ans", ans, 160'h0);
        check("midreset_o_valid", {159'b0, o_valid}, 160'h0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        start(blk_abc, dig_abc, smp);
        wait_done(smp, lat);
        check("after_reset_latency", lat, 81);

        // Randomized blocks against the model
        for (int v = 0; v < 200; v++) begin
            for (int w = 0; w < 16; w++) rblk[w*32 +: 32] = $urandom();
            start(rblk, model(rblk), smp);
            wait_done(smp, lat);
        end
        repeat (5) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
